// File: rtl/seq_verifier.sv
// Multi-cycle login verifier: byte-serial password hash, then a one-entry-per-cycle table search.
// Optional per-user failed-attempt lockout is compiled in with `define LOCKOUT_EN.
module seq_verifier #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_USERS = 8,
    parameter int unsigned HASH_W    = 32,
    parameter int unsigned MAX_FAILS = 3,
    localparam int unsigned AW       = $clog2(NUM_USERS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] username,
    input  logic [DATA_W-1:0] password,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_user,
    input  logic [HASH_W-1:0] prog_hash,
    input  logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic              locked,
    output logic [AW-1:0]     match_addr
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned STEPS = (NB > NUM_USERS) ? NB : NUM_USERS;
    localparam int unsigned SW    = $clog2(STEPS) + 1;

    if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a non-zero multiple of 8");
    end
    if (NUM_USERS < 2 || (NUM_USERS & (NUM_USERS - 1)) != 0) begin : g_bad_num_users
        $error("NUM_USERS must be a power of 2 and at least 2");
    end
    if (HASH_W < 8) begin : g_bad_hash_w
        $error("HASH_W must be at least 8");
    end
    if (MAX_FAILS < 1) begin : g_bad_max_fails
        $error("MAX_FAILS must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StHash, StSearch, StResult} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] user_q;
    logic [DATA_W-1:0] pwd_q;
    logic [HASH_W-1:0] hash_q;
    logic              term_q;
    logic [SW-1:0]     step_q;
    logic              found_q;
    logic [AW-1:0]     match_q;
    logic [HASH_W-1:0] match_hash_q;
    logic              match_stale_q;

    // Snapshot of the entry overwritten in the same cycle a start was accepted,
    // so the search still sees the pre-write contents of that entry.
    logic              stale_q;
    logic [AW-1:0]     stale_addr_q;
    logic [DATA_W-1:0] old_user_q;
    logic [HASH_W-1:0] old_hash_q;
    logic              old_en_q;

    logic [DATA_W-1:0] tab_user [NUM_USERS];
    logic [HASH_W-1:0] tab_hash [NUM_USERS];
    logic [NUM_USERS-1:0] tab_en;

`ifdef LOCKOUT_EN
    localparam int unsigned CW = $clog2(MAX_FAILS + 1);
    logic [CW-1:0] fail_cnt [NUM_USERS];
    logic [CW-1:0] old_cnt_q;
    logic [CW-1:0] match_cnt_q;
    logic [CW-1:0] cur_cnt;
`endif

    logic              accept;
    logic              wr_en;
    logic [AW-1:0]     idx;
    logic [7:0]        cur_byte;
    logic [HASH_W-1:0] hash_next;
    logic [DATA_W-1:0] cur_user;
    logic [HASH_W-1:0] cur_hash;
    logic              cur_en;
    logic              cur_stale;
    logic              hit;
    logic              hash_eq;

    assign accept    = (state_q == StIdle) && !busy && start;
    assign wr_en     = (state_q == StIdle) && !busy && prog_we;
    assign idx       = step_q[AW-1:0];
    assign cur_byte  = pwd_q[DATA_W-1 -: 8];
    assign hash_next = {hash_q[HASH_W-6:0], hash_q[HASH_W-1:HASH_W-5]} ^ HASH_W'(cur_byte);
    assign cur_stale = stale_q && (idx == stale_addr_q);
    assign hit       = cur_en && (cur_user == user_q) && (user_q != '0);
    assign hash_eq   = (match_hash_q == hash_q);

    always_comb begin
        cur_user = tab_user[idx];
        cur_hash = tab_hash[idx];
        cur_en   = tab_en[idx];
        if (cur_stale) begin
            cur_user = old_user_q;
            cur_hash = old_hash_q;
            cur_en   = old_en_q;
        end
    end

`ifdef LOCKOUT_EN
    always_comb begin
        cur_cnt = cur_stale ? old_cnt_q : fail_cnt[idx];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            locked        <= 1'b0;
            match_addr    <= '0;
            user_q        <= '0;
            pwd_q         <= '0;
            hash_q        <= '0;
            term_q        <= 1'b0;
            step_q        <= '0;
            found_q       <= 1'b0;
            match_q       <= '0;
            match_hash_q  <= '0;
            match_stale_q <= 1'b0;
            stale_q       <= 1'b0;
            stale_addr_q  <= '0;
            old_user_q    <= '0;
            old_hash_q    <= '0;
            old_en_q      <= 1'b0;
`ifdef LOCKOUT_EN
            old_cnt_q     <= '0;
            match_cnt_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // busy is still high during the done cycle; drop it one cycle later
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (accept) begin
                        busy         <= 1'b1;
                        valid        <= 1'b0;
                        locked       <= 1'b0;
                        match_addr   <= '0;
                        user_q       <= username;
                        pwd_q        <= password;
                        hash_q       <= '0;
                        term_q       <= 1'b0;
                        step_q       <= '0;
                        found_q      <= 1'b0;
                        stale_q      <= prog_we;
                        stale_addr_q <= prog_addr;
                        old_user_q   <= tab_user[prog_addr];
                        old_hash_q   <= tab_hash[prog_addr];
                        old_en_q     <= tab_en[prog_addr];
`ifdef LOCKOUT_EN
                        old_cnt_q    <= fail_cnt[prog_addr];
`endif
                        state_q      <= StHash;
                    end
                end
                StHash: begin
                    if (cur_byte == 8'h00) begin
                        term_q <= 1'b1;
                    end else if (!term_q) begin
                        hash_q <= hash_next;
                    end
                    pwd_q <= pwd_q << 8;
                    if (step_q == SW'(NB - 1)) begin
                        step_q  <= '0;
                        state_q <= StSearch;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StSearch: begin
                    if (!found_q && hit) begin
                        found_q       <= 1'b1;
                        match_q       <= idx;
                        match_hash_q  <= cur_hash;
                        match_stale_q <= cur_stale;
`ifdef LOCKOUT_EN
                        match_cnt_q   <= cur_cnt;
`endif
                    end
                    if (step_q == SW'(NUM_USERS - 1)) begin
                        step_q  <= '0;
                        state_q <= StResult;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                StResult: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                    if (!found_q) begin
                        valid      <= 1'b0;
                        locked     <= 1'b0;
                        match_addr <= '0;
                    end else begin
                        match_addr <= match_q;
`ifdef LOCKOUT_EN
                        if (match_cnt_q == CW'(MAX_FAILS)) begin
                            valid  <= 1'b0;
                            locked <= 1'b1;
                        end else begin
                            valid  <= hash_eq;
                            locked <= 1'b0;
                        end
`else
                        valid  <= hash_eq;
                        locked <= 1'b0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tab_en <= '0;
            for (int i = 0; i < int'(NUM_USERS); i++) begin
                tab_user[i] <= '0;
                tab_hash[i] <= '0;
`ifdef LOCKOUT_EN
                fail_cnt[i] <= '0;
`endif
            end
        end else begin
            if (wr_en) begin
                tab_user[prog_addr] <= prog_user;
                tab_hash[prog_addr] <= prog_hash;
                tab_en[prog_addr]   <= prog_en;
`ifdef LOCKOUT_EN
                fail_cnt[prog_addr] <= '0;
`endif
            end
`ifdef LOCKOUT_EN
            // An entry rewritten at start keeps its fresh counter; the old attempt is moot
            if (state_q == StResult && found_q && !match_stale_q &&
                match_cnt_q != CW'(MAX_FAILS)) begin
                fail_cnt[match_q] <= hash_eq ? '0 : match_cnt_q + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_verifier.sv
// Scoreboard bench for seq_verifier: a string-level reference model predicts each verification,
// and an independent monitor checks every done pulse against the queued expectation.
module tb_seq_verifier;

    localparam int DATA_W    = 64;
    localparam int NUM_USERS = 8;
    localparam int HASH_W    = 32;
    localparam int MAX_FAILS = 3;
    localparam int AW        = 3;
    localparam int NB        = DATA_W / 8;
    localparam int LAT       = NB + NUM_USERS + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] username = '0;
    logic [DATA_W-1:0] password = '0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [DATA_W-1:0] prog_user = '0;
    logic [HASH_W-1:0] prog_hash = '0;
    logic              prog_en = 1'b0;
    logic              busy, done, valid, locked;
    logic [AW-1:0]     match_addr;

    seq_verifier #(
        .DATA_W(DATA_W), .NUM_USERS(NUM_USERS), .HASH_W(HASH_W), .MAX_FAILS(MAX_FAILS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .username(username), .password(password),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_user(prog_user),
        .prog_hash(prog_hash), .prog_en(prog_en), .busy(busy), .done(done),
        .valid(valid), .locked(locked), .match_addr(match_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          v;
        logic          l;
        logic [AW-1:0] a;
        int            due;
    } exp_t;
    exp_t sbq[$];

    logic [DATA_W-1:0] m_user [NUM_USERS];
    logic [HASH_W-1:0] m_hash [NUM_USERS];
    bit                m_en   [NUM_USERS];
    int                m_cnt  [NUM_USERS];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [HASH_W-1:0] ref_hash(input logic [DATA_W-1:0] s);
        logic [HASH_W-1:0] h = '0;
        logic [7:0]        b;
        for (int i = 0; i < NB; i++) begin
            b = 8'(s >> (DATA_W - 8 * (i + 1)));
            if (b == 8'h00) break;
            h = ((h << 5) | (h >> (HASH_W - 5))) ^ HASH_W'(b);
        end
        return h;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_USERS; i++) begin
            m_user[i] = '0;
            m_hash[i] = '0;
            m_en[i]   = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_write(input int a, input logic [DATA_W-1:0] u,
                               input logic [HASH_W-1:0] h, input bit en);
        m_user[a] = u;
        m_hash[a] = h;
        m_en[a]   = en;
        m_cnt[a]  = 0;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("valid", valid, e.v);
                check("locked", locked, e.l);
                check("match_addr", match_addr, e.a);
                check("latency_cycle", cyc, e.due);
                check("busy_at_done", busy, 1);
            end
        end
    end

    task automatic prog(input int a, input logic [DATA_W-1:0] u,
                        input logic [HASH_W-1:0] h, input bit en);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = AW'(a); prog_user = u; prog_hash = h; prog_en = en;
        model_write(a, u, h, en);
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic launch(input logic [DATA_W-1:0] u, input logic [DATA_W-1:0] p,
                          input bit we, input int wa, input logic [DATA_W-1:0] wu,
                          input logic [HASH_W-1:0] wh, input bit wen);
        exp_t e;
        int   j;
        bit   heq;
        @(negedge clk);
        j = -1;
        if (u != '0) begin
            for (int k = 0; k < NUM_USERS; k++) begin
                if (m_en[k] && m_user[k] == u) begin
                    j = k;
                    break;
                end
            end
        end
        e.v = 1'b0; e.l = 1'b0; e.a = '0;
        e.due = cyc + 1 + LAT;
        if (j >= 0) begin
            e.a = AW'(j);
            heq = (ref_hash(p) == m_hash[j]);
`ifdef LOCKOUT_EN
            if (m_cnt[j] == MAX_FAILS) begin
                e.l = 1'b1;
            end else begin
                e.v = heq;
                m_cnt[j] = heq ? 0 : m_cnt[j] + 1;
            end
`else
            e.v = heq;
`endif
        end
        sbq.push_back(e);
        if (we) model_write(wa, wu, wh, wen);
        start = 1'b1; username = u; password = p;
        prog_we = we; prog_addr = AW'(wa); prog_user = wu; prog_hash = wh; prog_en = wen;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0 && !busy) break;
        end
        if (k == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle_timeout: got %0d pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run(input logic [DATA_W-1:0] u, input logic [DATA_W-1:0] p);
        launch(u, p, 1'b0, 0, '0, '0, 1'b0);
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_match_addr"}, match_addr, 0);
    endtask

    function automatic logic [DATA_W-1:0] rand_str();
        logic [DATA_W-1:0] s = '0;
        int len;
        len = $urandom_range(0, NB);
        for (int i = 0; i < NB; i++) begin
            logic [7:0] b;
            if (i < len) b = 8'($urandom_range(1, 255));
            else if (i == len) b = 8'h00;
            else b = 8'($urandom_range(0, 255));
            s = (s << 8) | DATA_W'(b);
        end
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    logic [DATA_W-1:0] bob, eve, ab, ac, carol;
    logic [DATA_W-1:0] upool [4];
    logic [DATA_W-1:0] ppool [4];

    initial begin
        bob   = {24'h424F42, 40'h0};
        eve   = {24'h455645, 40'h0};
        carol = {40'h4341524F4C, 24'h0};
        ab    = {16'h4142, 48'h0};
        ac    = {16'h4143, 48'h0};
        model_clear();

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic match, wrong password, unknown user
        prog(2, bob, 32'h862, 1'b1);
        run(bob, ab);
        run(bob, ac);
        run(eve, ab);

        // Lowest index wins; disabled entry is skipped
        prog(1, carol, ref_hash(ab), 1'b1);
        prog(5, carol, ref_hash(ac), 1'b1);
        run(carol, ab);
        prog(1, carol, ref_hash(ab), 1'b0);
        run(carol, ac);

        // Same-cycle write and start: verification sees the old entry
        launch(bob, ab, 1'b1, 2, bob, 32'hDEAD, 1'b1);
        wait_idle();
        run(bob, ab);
        prog(2, bob, 32'h862, 1'b1);

`ifdef LOCKOUT_EN
        repeat (3) run(bob, ac);
        run(bob, ab);
        prog(2, bob, 32'h862, 1'b1);
        run(bob, ab);
`endif

        // start and prog_we while busy are both ignored
        launch(bob, ab, 1'b0, 0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1; username = eve; password = ab;
        prog_we = 1'b1; prog_addr = 2; prog_user = eve; prog_hash = 32'h0; prog_en = 1'b1;
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        run(eve, ab);
        run(bob, ab);

        // Randomised traffic over a small pool so matches and collisions are common
        upool[0] = '0; upool[1] = bob; upool[2] = eve; upool[3] = carol;
        for (int i = 0; i < 4; i++) ppool[i] = rand_str();
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r == 0) begin
                prog($urandom_range(0, NUM_USERS - 1), upool[$urandom_range(0, 3)],
                     ref_hash(ppool[$urandom_range(0, 3)]), 1'($urandom_range(0, 3) != 0));
            end else if (r == 1) begin
                launch(upool[$urandom_range(0, 3)], ppool[$urandom_range(0, 3)], 1'b1,
                       $urandom_range(0, NUM_USERS - 1), upool[$urandom_range(0, 3)],
                       ref_hash(ppool[$urandom_range(0, 3)]), 1'b1);
                wait_idle();
            end else begin
                run(upool[$urandom_range(0, 3)], ppool[$urandom_range(0, 3)]);
            end
        end

        // Reset mid-operation: outputs clear at once, no done, table wiped
        prog(2, bob, 32'h862, 1'b1);
        launch(bob, ab, 1'b0, 0, '0, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        sbq.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        run(bob, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
